// File: rtl/uart_cmd_wrapper_pkg.sv
// Shared types and frame constants for the 3-byte serial command receiver.
package uart_cmd_wrapper_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} rx_state_t;
  localparam int FRAME_BYTES = 3;
  localparam int DATA_W = 8 * (FRAME_BYTES - 1);
endpackage

// File: rtl/uart_cmd_wrapper_uart.sv
// 8N1 UART transceiver: start-edge detect with mid-bit sampling on RX,
// 10-bit shift-out on TX, one-cycle tx_done at the end of the stop bit.
module uart_cmd_wrapper_uart #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);

  logic          rx_ff1, rx_s;
  logic          rx_busy;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bit_cnt;
  logic          tx_active;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bit_cnt;
  logic [9:0]    tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      rx_ff1 <= RX;
      rx_s   <= rx_ff1;
    end
  end

  // Shifting on the start sample too drops the start bit out of the 8-bit reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy    <= 1'b0;
      rx_baud    <= '0;
      rx_bit_cnt <= '0;
      rx_data    <= '0;
      rx_rdy     <= 1'b0;
    end else begin
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s) begin
          rx_busy    <= 1'b1;
          rx_baud    <= BAUD_HALF;
          rx_bit_cnt <= 4'd10;
          rx_rdy     <= 1'b0;
        end
      end else if (rx_baud == '0) begin
        rx_baud    <= BAUD_LAST;
        rx_bit_cnt <= rx_bit_cnt - 4'd1;
        if (rx_bit_cnt == 4'd1) begin
          rx_busy <= 1'b0;
          rx_rdy  <= rx_s;
        end else begin
          rx_data <= {rx_s, rx_data[7:1]};
        end
      end else begin
        rx_baud <= rx_baud - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_active  <= 1'b0;
      tx_baud    <= '0;
      tx_bit_cnt <= '0;
      tx_shift   <= '1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt && !tx_active) begin
        tx_active  <= 1'b1;
        tx_baud    <= BAUD_LAST;
        tx_bit_cnt <= 4'd10;
        tx_shift   <= {1'b1, tx_data, 1'b0};
      end else if (tx_active) begin
        if (tx_baud == '0) begin
          tx_baud    <= BAUD_LAST;
          tx_bit_cnt <= tx_bit_cnt - 4'd1;
          tx_shift   <= {1'b1, tx_shift[9:1]};
          if (tx_bit_cnt == 4'd1) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
          end
        end else begin
          tx_baud <= tx_baud - 1'b1;
        end
      end
    end
  end

  assign TX = tx_shift[0];
endmodule

// File: rtl/uart_cmd_wrapper.sv
// Command frame receiver (cmd, data hi, data lo) with inter-byte timeout,
// plus single-byte response transmit, around the UART transceiver.
//   state | meaning
//   IDLE  | waiting for cmd byte; timer held at 0
//   HIGH  | cmd held, waiting for data[15:8]
//   LOW   | data[15:8] held, waiting for data[7:0]
module uart_cmd_wrapper
  import uart_cmd_wrapper_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int BAUD_DIV    = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic              TX,
  output logic [7:0]        cmd,
  output logic [DATA_W-1:0] data,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  input  logic [7:0]        resp,
  input  logic              send_resp,
  output logic              resp_sent,
  output logic              frm_err
);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  rx_state_t        rx_state;
  logic [TMR_W-1:0] timer;
  logic [7:0]       cmd_hold;
  logic [7:0]       high_hold;
  logic             rx_rdy;
  logic             clr_rx_rdy;
  logic [7:0]       rx_data;
  logic             trmt;
  logic             tx_done;
  logic             tx_busy;

  uart_cmd_wrapper_uart #(.BAUD_DIV(BAUD_DIV)) iUART (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_rdy),
    .rx_data    (rx_data),
    .trmt       (trmt),
    .tx_data    (resp),
    .tx_done    (tx_done)
  );

  // Every state consumes a ready byte, so the UART flag is released at once.
  assign clr_rx_rdy = rx_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= IDLE;
      timer     <= '0;
      cmd_hold  <= '0;
      high_hold <= '0;
      cmd       <= '0;
      data      <= '0;
      cmd_rdy   <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      case (rx_state)
        IDLE: begin
          timer <= '0;
          if (rx_rdy) begin
            cmd_hold <= rx_data;
            cmd_rdy  <= 1'b0;
            rx_state <= HIGH;
          end
        end
        HIGH: begin
          if (rx_rdy) begin
            high_hold <= rx_data;
            timer     <= '0;
            rx_state  <= LOW;
          end else if (timer == TMR_LAST) begin
            frm_err  <= 1'b1;
            timer    <= '0;
            rx_state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LOW: begin
          if (rx_rdy) begin
            cmd      <= cmd_hold;
            data     <= {high_hold, rx_data};
            cmd_rdy  <= 1'b1;
            timer    <= '0;
            rx_state <= IDLE;
          end else if (timer == TMR_LAST) begin
            frm_err  <= 1'b1;
            timer    <= '0;
            rx_state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer    <= '0;
          rx_state <= IDLE;
        end
      endcase
    end
  end

  assign trmt = send_resp & ~tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy   <= 1'b0;
      resp_sent <= 1'b0;
    end else if (trmt) begin
      tx_busy   <= 1'b1;
      resp_sent <= 1'b0;
    end else if (tx_done) begin
      tx_busy   <= 1'b0;
      resp_sent <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: serial frames in, response byte out.
module tb_uart_cmd_wrapper;
  localparam int BAUD = 16;
  localparam int TMO  = 400;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        frm_err;

  int checks = 0;
  int failures = 0;
  int frm_cnt = 0;

  uart_cmd_wrapper #(.TIMEOUT_CYC(TMO), .BAUD_DIV(BAUD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .frm_err     (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frm_err === 1'b1) frm_cnt <= frm_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      RX = bits[i];
      repeat (BAUD) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [15:0] d);
    send_byte(c);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic pulse_send(input logic [7:0] r);
    @(posedge clk); #1;
    resp = r;
    send_resp = 1'b1;
    @(posedge clk); #1;
    send_resp = 1'b0;
    resp = 8'h00;
  endtask

  task automatic get_tx(output logic [7:0] b, output logic ok);
    logic found;
    found = 1'b0;
    ok = 1'b0;
    b = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (TX === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      repeat (BAUD / 2) @(negedge clk);
      ok = (TX === 1'b0);
      for (int j = 0; j < 8; j++) begin
        repeat (BAUD) @(negedge clk);
        b[j] = TX;
      end
      repeat (BAUD) @(negedge clk);
      ok = ok && (TX === 1'b1);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] c, input logic [15:0] d,
                             input logic r);
    @(negedge clk);
    check({tag, "_cmd"}, 32'(cmd), 32'(c));
    check({tag, "_data"}, 32'(data), 32'(d));
    check({tag, "_rdy"}, 32'(cmd_rdy), 32'(r));
  endtask

  initial begin
    logic [7:0] rb;
    logic       rok;
    logic       seen;
    int         snap;
    int         lows;

    rst_n = 1'b0;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    resp = 8'h00;
    send_resp = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_cmd", 32'(cmd), 32'h00);
    check("rst_data", 32'(data), 32'h0000);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("rst_resp_sent", 32'(resp_sent), 32'h0);
    check("rst_frm_err", 32'(frm_err), 32'h0);
    check("rst_tx", 32'(TX), 32'h1);

    // basic frame then acknowledge
    send_frame(8'h02, 16'h1234);
    check_frame("f1", 8'h02, 16'h1234, 1'b1);
    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    check_frame("f1_clr", 8'h02, 16'h1234, 1'b0);

    // back-to-back frames, no acknowledge
    send_frame(8'h05, 16'hABCD);
    check_frame("f2", 8'h05, 16'hABCD, 1'b1);
    send_byte(8'h06);
    check_frame("f3_b1", 8'h05, 16'hABCD, 1'b0);
    send_byte(8'h00);
    send_byte(8'h01);
    check_frame("f3", 8'h06, 16'h0001, 1'b1);

    // partial frame dropped on timeout
    snap = frm_cnt;
    send_byte(8'h03);
    send_byte(8'h55);
    repeat (TMO + 100) @(posedge clk);
    check_frame("tmo_hold", 8'h06, 16'h0001, 1'b0);
    check("tmo_frm_err_cnt", 32'(frm_cnt - snap), 32'd1);
    send_frame(8'h07, 16'h0010);
    check_frame("tmo_next", 8'h07, 16'h0010, 1'b1);
    check("tmo_frm_err_cnt2", 32'(frm_cnt - snap), 32'd1);

    // response transmit with an ignored second request
    fork
      get_tx(rb, rok);
      begin
        pulse_send(8'hA5);
        repeat (50) @(posedge clk);
        pulse_send(8'h3C);
        @(negedge clk);
        check("tx_resp_sent_busy", 32'(resp_sent), 32'h0);
      end
    join
    check("tx_ok", 32'(rok), 32'h1);
    check("tx_byte", 32'(rb), 32'hA5);
    repeat (20) @(negedge clk);
    check("tx_resp_sent_done", 32'(resp_sent), 32'h1);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
    end
    check("tx_no_second", 32'(lows), 32'd0);

    // full duplex
    fork
      get_tx(rb, rok);
      begin
        pulse_send(8'hA5);
        @(negedge clk);
        check("dup_resp_sent_clr", 32'(resp_sent), 32'h0);
      end
      send_frame(8'h01, 16'hBEEF);
    join
    check("dup_tx_ok", 32'(rok), 32'h1);
    check("dup_tx_byte", 32'(rb), 32'hA5);
    check_frame("dup", 8'h01, 16'hBEEF, 1'b1);
    check("dup_resp_sent", 32'(resp_sent), 32'h1);

    // clr_cmd_rdy coincident with completion: set wins
    send_byte(8'h0A);
    send_byte(8'h0B);
    seen = 1'b0;
    fork
      send_byte(8'h0C);
      begin
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (dut.rx_rdy === 1'b1) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          clr_cmd_rdy = 1'b1;
          @(posedge clk); #1 clr_cmd_rdy = 1'b0;
        end
      end
    join
    check("coin_seen", 32'(seen), 32'h1);
    check_frame("coin", 8'h0A, 16'h0B0C, 1'b1);

    // reset mid-frame
    send_byte(8'h11);
    send_byte(8'h22);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    check_frame("mrst", 8'h00, 16'h0000, 1'b0);
    check("mrst_resp_sent", 32'(resp_sent), 32'h0);
    check("mrst_frm_err", 32'(frm_err), 32'h0);
    check("mrst_tx", 32'(TX), 32'h1);
    @(posedge clk); #1 rst_n = 1'b1;
    snap = frm_cnt;
    repeat (TMO + 100) @(posedge clk);
    check("mrst_no_frm_err", 32'(frm_cnt - snap), 32'd0);
    send_frame(8'h09, 16'h0102);
    check_frame("mrst_next", 8'h09, 16'h0102, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
